// File: rtl/bitcell_array_4x4_pkg.sv
// Shared parameters and arithmetic helpers
// for the 4x4 compute-in-memory bitcell array.
package bitcell_array_4x4_pkg;

    localparam int unsigned N_DEF = 4;

    // Two-operand sum truncated to n bits; n >= 32 keeps all bits.
    function automatic logic [31:0] wrap_sum(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned n
    );
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/bitcell_array_4x4_bitcell.sv
// Single storage bit with write enable and
// activation-gated read-out.
module bitcell
    import bitcell_array_4x4_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  logic d,
    input  logic act,
    output logic q
);

    logic w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w <= 1'b0;
        end else if (we) begin
            w <= d;
        end
    end

    assign q = w & act;

endmodule

// File: rtl/bitcell_array_4x4.sv
// NxN bitcell array with row-gated carry-save
// adder tree and registered MAC output.
module bitcell_array_4x4
    import bitcell_array_4x4_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] WL,
    input  logic [N-1:0] BL,
    input  logic [N-1:0] INPUT,
    input  logic [N-1:0] SI,
    input  logic [N-1:0] CI,
    output logic [N-1:0] OUTPUT
);

    logic [N-1:0] prow [N];
    logic         compute;
    logic [N-1:0] sum_nxt;

    // Row i is written from BL[j] per column and gated by BL[i].
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            bitcell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (WL[i]),
                .d     (BL[j]),
                .act   (BL[i]),
                .q     (prow[i][j])
            );
        end
    end

    assign compute = ~|WL;

    // Fold every operand into a sum/carry pair, then one final add.
    always_comb begin
        logic [N-1:0] s;
        logic [N-1:0] c;
        logic [N-1:0] mj;
        logic [31:0]  tot;
        s  = SI;
        c  = INPUT;
        mj = (s & c) | (s & CI) | (c & CI);
        s  = s ^ c ^ CI;
        c  = mj << 1;
        for (int k = 0; k < N; k++) begin
            mj = (s & c) | (s & prow[k]) | (c & prow[k]);
            s  = s ^ c ^ prow[k];
            c  = mj << 1;
        end
        tot     = wrap_sum(32'(s), 32'(c), N);
        sum_nxt = tot[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OUTPUT <= '0;
        end else if (compute) begin
            OUTPUT <= sum_nxt;
        end
    end

endmodule

// File: tb/tb_bitcell_array_4x4.sv
// Directed and random scoreboard bench
// for bitcell_array_4x4.
module tb_bitcell_array_4x4;
    import bitcell_array_4x4_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] WL;
    logic [3:0] BL;
    logic [3:0] INPUT;
    logic [3:0] SI;
    logic [3:0] CI;
    logic [3:0] OUTPUT;

    logic [3:0] wm [4];
    logic [3:0] om;
    logic [3:0] exp_q [$];
    int         compared;
    int         mismatched;

    bitcell_array_4x4 #(.N(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .WL     (WL),
        .BL     (BL),
        .INPUT  (INPUT),
        .SI     (SI),
        .CI     (CI),
        .OUTPUT (OUTPUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input string      tag,
        input logic       r,
        input logic [3:0] wl,
        input logic [3:0] bl,
        input logic [3:0] si,
        input logic [3:0] ina,
        input logic [3:0] ci
    );
        logic [31:0] acc;
        logic [3:0]  e;
        rst_n = r;
        WL    = wl;
        BL    = bl;
        SI    = si;
        INPUT = ina;
        CI    = ci;
        if (!r) begin
            for (int i = 0; i < 4; i++) wm[i] = 4'd0;
            om = 4'd0;
        end else if (wl != 4'd0) begin
            for (int i = 0; i < 4; i++)
                if (wl[i]) wm[i] = bl;
        end else begin
            acc = 32'd0;
            acc = wrap_sum(acc, {28'd0, si}, 4);
            acc = wrap_sum(acc, {28'd0, ina}, 4);
            acc = wrap_sum(acc, {28'd0, ci}, 4);
            for (int i = 0; i < 4; i++)
                if (bl[i]) acc = wrap_sum(acc, {28'd0, wm[i]}, 4);
            om = acc[3:0];
        end
        exp_q.push_back(om);
        @(posedge clk);
        #1;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: observed %b expected <empty queue>", tag, OUTPUT);
        end else begin
            e = exp_q.pop_front();
            assert (OUTPUT === e) else begin
                mismatched++;
                $error("FAIL %s: observed %b expected %b", tag, OUTPUT, e);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        om         = 4'd0;
        for (int i = 0; i < 4; i++) wm[i] = 4'd0;
        rst_n = 1'b0;
        WL = 4'd0; BL = 4'd0; SI = 4'd0; INPUT = 4'd0; CI = 4'd0;
        @(negedge clk);

        step("reset",      1'b0, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0);
        step("rst_comp",   1'b1, 4'b0000, 4'b1111, 4'd0, 4'd0, 4'd0);

        step("wr_row0",    1'b1, 4'b0001, 4'b0110, 4'd7, 4'd7, 4'd7);
        step("wr_row1",    1'b1, 4'b0010, 4'b1101, 4'd3, 4'd3, 4'd3);
        for (int b = 0; b < 16; b++)
            step($sformatf("sweep_bl%0d", b), 1'b1, 4'b0000,
                 4'(b), 4'd0, 4'd0, 4'd0);

        step("rst2",       1'b0, 4'b1111, 4'b1111, 4'd0, 4'd0, 4'd0);
        step("addends",    1'b1, 4'b0000, 4'b1111, 4'b0101, 4'b0010, 4'b0001);
        step("addends_ff", 1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111);

        step("multi_wr",   1'b1, 4'b0111, 4'b1111, 4'd9, 4'd9, 4'd9);
        step("multi_comp", 1'b1, 4'b0000, 4'b0111, 4'd0, 4'd0, 4'd0);
        step("multi_hold", 1'b1, 4'b1000, 4'b0000, 4'd5, 4'd5, 4'd5);
        step("row3_zero",  1'b1, 4'b0000, 4'b1000, 4'd0, 4'd0, 4'd0);

        step("wr_k",       1'b1, 4'b0001, 4'b0110, 4'd0, 4'd0, 4'd0);
        step("comp_k1",    1'b1, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'd0);
        step("sweep_a",    1'b1, 4'b0000, 4'b0011, 4'd1, 4'd0, 4'd0);
        step("mid_rst",    1'b0, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'd0);
        step("post_rst",   1'b1, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'd0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] wl;
            wl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            step("random", ($urandom_range(0, 19) != 0), wl,
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
